// File: rtl/text2d_window_reader.sv
// text2d_window_reader
// Scans a 2D window (origin, size, stride) in raster order against a
// row-major frame memory with 1-cycle read latency. Out-of-frame elements
// become either a constant pad token or a clamped edge read. Results stream
// out through a 2-entry FIFO on a valid/ready handshake.
module text2d_window_reader #(
  parameter int BITDEPTH = 8,
  parameter int CHANNELS = 1,
  parameter int FRAME_W  = 64,
  parameter int FRAME_H  = 64,
  parameter int MAX_WIN  = 16,
  parameter int EW       = BITDEPTH * CHANNELS,
  parameter int ADDR_W   = $clog2(FRAME_W * FRAME_H),
  parameter int SW       = $clog2(MAX_WIN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [15:0]       cmd_x_i,
  input  logic [15:0]       cmd_y_i,
  input  logic [SW-1:0]     cmd_w_i,
  input  logic [SW-1:0]     cmd_h_i,
  input  logic [7:0]        cmd_sx_i,
  input  logic [7:0]        cmd_sy_i,
  input  logic              cmd_pad_mode_i,
  input  logic [EW-1:0]     cmd_pad_value_i,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [EW-1:0]     mem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [EW-1:0]     out_data_o,
  output logic              out_eol_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);

  // Coordinates are 18-bit signed: 16-bit origin plus 15*255 never wraps.
  localparam int CW = 18;
  localparam logic signed [CW-1:0] FW_S   = CW'(FRAME_W);
  localparam logic signed [CW-1:0] FH_S   = CW'(FRAME_H);
  localparam logic [ADDR_W-1:0]    FW_A   = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0]    XMAX_A = ADDR_W'(FRAME_W - 1);
  localparam logic [ADDR_W-1:0]    YMAX_A = ADDR_W'(FRAME_H - 1);
  localparam logic [SW-1:0]        ONE_W  = SW'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic signed [CW-1:0]   x0_q, x0_d, cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [SW-1:0]          w_q, w_d, h_q, h_d, i_q, i_d, j_q, j_d;
  logic [7:0]             sx_q, sx_d, sy_q, sy_d;
  logic                   pad_mode_q, pad_mode_d;
  logic [EW-1:0]          pad_value_q, pad_value_d;
  logic                   slot_valid_q, slot_valid_d, slot_pad_q, slot_pad_d;
  logic                   slot_eol_q, slot_eol_d, slot_last_q, slot_last_d;
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;
  logic [EW-1:0]          fifo_data_q [2];
  logic [EW-1:0]          fifo_data_d [2];
  logic                   fifo_eol_q [2];
  logic                   fifo_eol_d [2];
  logic                   fifo_last_q [2];
  logic                   fifo_last_d [2];
  logic                   done_q, done_d;

  logic                   accept_s, pop_s, issue_s, room_s, in_frame_s, pad_elem_s;
  logic                   row_end_s, last_elem_s;
  logic [2:0]             occ_s;
  logic [ADDR_W-1:0]      cx_s, cy_s, addr_s;
  logic [EW-1:0]          push_data_s;

  assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign out_valid_o = (fifo_cnt_q != 2'd0);
  assign out_data_o  = fifo_data_q[0];
  assign out_eol_o   = fifo_eol_q[0];
  assign out_last_o  = fifo_last_q[0];

  assign accept_s    = cmd_valid_i && cmd_ready_o;
  assign pop_s       = out_valid_o && out_ready_i;
  assign occ_s       = {1'b0, fifo_cnt_q} + {2'b00, slot_valid_q};
  assign room_s      = (occ_s < 3'd2);
  assign issue_s     = (state_q == S_SCAN) && (room_s || pop_s);
  assign in_frame_s  = !cur_x_q[CW-1] && (cur_x_q < FW_S) && !cur_y_q[CW-1] && (cur_y_q < FH_S);
  assign pad_elem_s  = !in_frame_s && !pad_mode_q;
  assign row_end_s   = (i_q == (w_q - ONE_W));
  assign last_elem_s = row_end_s && (j_q == (h_q - ONE_W));
  assign addr_s      = cy_s * FW_A + cx_s;
  assign mem_re_o    = issue_s && !pad_elem_s;
  assign mem_addr_o  = mem_re_o ? addr_s : {ADDR_W{1'b0}};
  assign push_data_s = slot_pad_q ? pad_value_q : mem_rdata_i;

  // Clamp the current coordinate into the frame (identity when in-frame).
  always_comb begin
    if (cur_x_q[CW-1]) begin
      cx_s = {ADDR_W{1'b0}};
    end else if (cur_x_q >= FW_S) begin
      cx_s = XMAX_A;
    end else begin
      cx_s = cur_x_q[ADDR_W-1:0];
    end
    if (cur_y_q[CW-1]) begin
      cy_s = {ADDR_W{1'b0}};
    end else if (cur_y_q >= FH_S) begin
      cy_s = YMAX_A;
    end else begin
      cy_s = cur_y_q[ADDR_W-1:0];
    end
  end

  // Next-state for command latch, raster scan, in-flight slot and done pulse.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    w_d         = w_q;
    h_d         = h_q;
    i_d         = i_q;
    j_d         = j_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    pad_mode_d  = pad_mode_q;
    pad_value_d = pad_value_q;
    slot_valid_d = 1'b0;
    slot_pad_d  = slot_pad_q;
    slot_eol_d  = slot_eol_q;
    slot_last_d = slot_last_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          x0_d        = {{(CW-16){cmd_x_i[15]}}, cmd_x_i};
          cur_x_d     = {{(CW-16){cmd_x_i[15]}}, cmd_x_i};
          cur_y_d     = {{(CW-16){cmd_y_i[15]}}, cmd_y_i};
          w_d         = cmd_w_i;
          h_d         = cmd_h_i;
          i_d         = {SW{1'b0}};
          j_d         = {SW{1'b0}};
          sx_d        = (cmd_sx_i == 8'd0) ? 8'd1 : cmd_sx_i;
          sy_d        = (cmd_sy_i == 8'd0) ? 8'd1 : cmd_sy_i;
          pad_mode_d  = cmd_pad_mode_i;
          pad_value_d = cmd_pad_value_i;
          if ((cmd_w_i != {SW{1'b0}}) && (cmd_h_i != {SW{1'b0}})) begin
            state_d = S_SCAN;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (issue_s) begin
          slot_valid_d = 1'b1;
          slot_pad_d   = pad_elem_s;
          slot_eol_d   = row_end_s;
          slot_last_d  = last_elem_s;
          if (row_end_s) begin
            i_d     = {SW{1'b0}};
            j_d     = j_q + ONE_W;
            cur_x_d = x0_q;
            cur_y_d = cur_y_q + {{(CW-8){1'b0}}, sy_q};
          end else begin
            i_d     = i_q + ONE_W;
            cur_x_d = cur_x_q + {{(CW-8){1'b0}}, sx_q};
          end
          if (last_elem_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_SCAN;
          end
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DRAIN: begin
        if (pop_s && out_last_o) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Shift-style output FIFO: head always in entry 0 so outputs come from flops.
  always_comb begin
    fifo_cnt_d  = fifo_cnt_q;
    fifo_data_d = fifo_data_q;
    fifo_eol_d  = fifo_eol_q;
    fifo_last_d = fifo_last_q;
    case ({pop_s, slot_valid_q})
      2'b11: begin
        if (fifo_cnt_q == 2'd2) begin
          fifo_data_d[0] = fifo_data_q[1];
          fifo_eol_d[0]  = fifo_eol_q[1];
          fifo_last_d[0] = fifo_last_q[1];
          fifo_data_d[1] = push_data_s;
          fifo_eol_d[1]  = slot_eol_q;
          fifo_last_d[1] = slot_last_q;
        end else begin
          fifo_data_d[0] = push_data_s;
          fifo_eol_d[0]  = slot_eol_q;
          fifo_last_d[0] = slot_last_q;
        end
      end
      2'b10: begin
        fifo_data_d[0] = fifo_data_q[1];
        fifo_eol_d[0]  = fifo_eol_q[1];
        fifo_last_d[0] = fifo_last_q[1];
        fifo_cnt_d     = fifo_cnt_q - 2'd1;
      end
      2'b01: begin
        if (fifo_cnt_q == 2'd0) begin
          fifo_data_d[0] = push_data_s;
          fifo_eol_d[0]  = slot_eol_q;
          fifo_last_d[0] = slot_last_q;
        end else begin
          fifo_data_d[1] = push_data_s;
          fifo_eol_d[1]  = slot_eol_q;
          fifo_last_d[1] = slot_last_q;
        end
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      default: begin
        fifo_cnt_d = fifo_cnt_q;
      end
    endcase
  end

  // State register with synchronous reset; a reset drops any in-flight read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      x0_q           <= {CW{1'b0}};
      cur_x_q        <= {CW{1'b0}};
      cur_y_q        <= {CW{1'b0}};
      w_q            <= {SW{1'b0}};
      h_q            <= {SW{1'b0}};
      i_q            <= {SW{1'b0}};
      j_q            <= {SW{1'b0}};
      sx_q           <= 8'd1;
      sy_q           <= 8'd1;
      pad_mode_q     <= 1'b0;
      pad_value_q    <= {EW{1'b0}};
      slot_valid_q   <= 1'b0;
      slot_pad_q     <= 1'b0;
      slot_eol_q     <= 1'b0;
      slot_last_q    <= 1'b0;
      fifo_cnt_q     <= 2'd0;
      fifo_data_q[0] <= {EW{1'b0}};
      fifo_data_q[1] <= {EW{1'b0}};
      fifo_eol_q[0]  <= 1'b0;
      fifo_eol_q[1]  <= 1'b0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      x0_q           <= x0_d;
      cur_x_q        <= cur_x_d;
      cur_y_q        <= cur_y_d;
      w_q            <= w_d;
      h_q            <= h_d;
      i_q            <= i_d;
      j_q            <= j_d;
      sx_q           <= sx_d;
      sy_q           <= sy_d;
      pad_mode_q     <= pad_mode_d;
      pad_value_q    <= pad_value_d;
      slot_valid_q   <= slot_valid_d;
      slot_pad_q     <= slot_pad_d;
      slot_eol_q     <= slot_eol_d;
      slot_last_q    <= slot_last_d;
      fifo_cnt_q     <= fifo_cnt_d;
      fifo_data_q    <= fifo_data_d;
      fifo_eol_q     <= fifo_eol_d;
      fifo_last_q    <= fifo_last_d;
      done_q         <= done_d;
    end
  end

endmodule

// File: tb/tb_text2d_window_reader.sv
// Directed testbench for text2d_window_reader against a 64x64 frame model
// where mem[a] = a & 0xFF with one-cycle read latency.
module tb_text2d_window_reader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [15:0] cmd_x_i, cmd_y_i;
  logic [4:0]  cmd_w_i, cmd_h_i;
  logic [7:0]  cmd_sx_i, cmd_sy_i;
  logic        cmd_pad_mode_i;
  logic [7:0]  cmd_pad_value_i;
  logic        mem_re_o;
  logic [11:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  logic        out_valid_o, out_ready_i;
  logic [7:0]  out_data_o;
  logic        out_eol_o, out_last_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  // Observations collected by run_cmd
  int od[$];
  int oc[$];
  bit oe[$];
  bit ol[$];
  int ma[$];
  int done_cyc, done_cnt, hold_err, valid_cyc;
  bit timeout, busy_at1, ready_at_done;

  text2d_window_reader dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_w_i(cmd_w_i), .cmd_h_i(cmd_h_i),
    .cmd_sx_i(cmd_sx_i), .cmd_sy_i(cmd_sy_i),
    .cmd_pad_mode_i(cmd_pad_mode_i), .cmd_pad_value_i(cmd_pad_value_i),
    .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_eol_o(out_eol_o), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Frame memory model; garbage when no read was issued.
  always_ff @(posedge clk) begin
    if (mem_re_o) mem_rdata_i <= mem_addr_o[7:0];
    else          mem_rdata_i <= 8'hEE;
  end

  // Issue one command and observe cycle by cycle (rel = cycles after accept).
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input int sx, input int sy, input bit mode,
                         input logic [7:0] pad, input int rmode, input int stop_after);
    int rel, tail;
    bit prev_stall, tog, pe, pl;
    logic [7:0] pd;
    od.delete(); oc.delete(); oe.delete(); ol.delete(); ma.delete();
    done_cyc = -1; done_cnt = 0; hold_err = 0; valid_cyc = 0;
    timeout = 1'b0; busy_at1 = 1'b0; ready_at_done = 1'b0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1;
    cmd_x_i = 16'(x); cmd_y_i = 16'(y); cmd_w_i = 5'(w); cmd_h_i = 5'(h);
    cmd_sx_i = 8'(sx); cmd_sy_i = 8'(sy);
    cmd_pad_mode_i = mode; cmd_pad_value_i = pad;
    out_ready_i = (rmode == 0);
    rel = 0; tail = -1; prev_stall = 1'b0; tog = 1'b0; pd = 8'h00; pe = 1'b0; pl = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      rel++;
      cmd_valid_i = 1'b0;
      if (rmode == 0) out_ready_i = 1'b1;
      else begin
        tog = !tog;
        out_ready_i = tog && ($urandom_range(0, 3) != 0);
      end
      #1;
      if (rel == 1) busy_at1 = busy_o;
      if (prev_stall && (!out_valid_o || out_data_o !== pd || out_eol_o !== pe || out_last_o !== pl))
        hold_err++;
      if (out_valid_o) valid_cyc++;
      if (mem_re_o) ma.push_back(int'(mem_addr_o));
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = rel; ready_at_done = cmd_ready_o; end
      end
      if (out_valid_o && out_ready_i) begin
        od.push_back(int'(out_data_o)); oc.push_back(rel);
        oe.push_back(out_eol_o); ol.push_back(out_last_o);
      end
      prev_stall = out_valid_o && !out_ready_i;
      pd = out_data_o; pe = out_eol_o; pl = out_last_o;
      if (stop_after > 0 && od.size() == stop_after) break;
      if (done_cyc >= 0) begin
        if (tail < 0) tail = 3;
        else if (tail == 0) break;
        else tail--;
      end
      if (rel >= 300) begin timeout = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cmd_valid_i = 1'b0; out_ready_i = 1'b0;
    cmd_x_i = 16'd0; cmd_y_i = 16'd0; cmd_w_i = 5'd0; cmd_h_i = 5'd0;
    cmd_sx_i = 8'd0; cmd_sy_i = 8'd0; cmd_pad_mode_i = 1'b0; cmd_pad_value_i = 8'd0;
    @(posedge clk); #1;
    checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready_in_reset got %b want 0", cmd_ready_o); end
    @(posedge clk); #1; rst_i = 1'b0; #1;
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready_o); end
    checks++; if (mem_re_o !== 1'b0 || mem_addr_o !== 12'd0) begin errors++; $display("FAIL rst_mem got re=%b addr=%0d want 0/0", mem_re_o, mem_addr_o); end
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== 8'd0 || out_eol_o !== 1'b0 || out_last_o !== 1'b0)
      begin errors++; $display("FAIL rst_out got v=%b d=%0d e=%b l=%b want all 0", out_valid_o, out_data_o, out_eol_o, out_last_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b/%b want 0/0", busy_o, done_o); end
  endtask

  task automatic test_basic();
    int exp_d[8] = '{194, 195, 196, 197, 2, 3, 4, 5};
    int exp_a[8] = '{194, 195, 196, 197, 258, 259, 260, 261};
    int got;
    run_cmd(2, 3, 4, 2, 1, 1, 1'b0, 8'h00, 0, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", timeout); end
    checks++; if (od.size() != 8) begin errors++; $display("FAIL basic_count got %0d want 8", od.size()); end
    checks++; if (ma.size() != 8) begin errors++; $display("FAIL basic_nreads got %0d want 8", ma.size()); end
    for (int k = 0; k < 8; k++) begin
      got = (k < od.size()) ? od[k] : -1;
      checks++; if (got != exp_d[k]) begin errors++; $display("FAIL basic_data[%0d] got %0d want %0d", k, got, exp_d[k]); end
      got = (k < oc.size()) ? oc[k] : -1;
      checks++; if (got != 3 + k) begin errors++; $display("FAIL basic_cycle[%0d] got %0d want %0d", k, got, 3 + k); end
      got = (k < oe.size()) ? int'(oe[k]) : -1;
      checks++; if (got != int'(k == 3 || k == 7)) begin errors++; $display("FAIL basic_eol[%0d] got %0d want %0d", k, got, int'(k == 3 || k == 7)); end
      got = (k < ol.size()) ? int'(ol[k]) : -1;
      checks++; if (got != int'(k == 7)) begin errors++; $display("FAIL basic_last[%0d] got %0d want %0d", k, got, int'(k == 7)); end
      got = (k < ma.size()) ? ma[k] : -1;
      checks++; if (got != exp_a[k]) begin errors++; $display("FAIL basic_addr[%0d] got %0d want %0d", k, got, exp_a[k]); end
    end
    checks++; if (done_cyc != 11) begin errors++; $display("FAIL basic_done_cycle got %0d want 11", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    checks++; if (ready_at_done !== 1'b1) begin errors++; $display("FAIL basic_ready_at_done got %b want 1", ready_at_done); end
    checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy_at1); end
  endtask

  task automatic test_pad_const();
    int exp_d[3] = '{170, 0, 1};
    int got;
    // zero strides must behave as stride 1
    run_cmd(-1, 0, 3, 1, 0, 0, 1'b0, 8'hAA, 0, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL padc_timeout got %b want 0", timeout); end
    checks++; if (ma.size() != 2) begin errors++; $display("FAIL padc_nreads got %0d want 2", ma.size()); end
    for (int k = 0; k < 3; k++) begin
      got = (k < od.size()) ? od[k] : -1;
      checks++; if (got != exp_d[k]) begin errors++; $display("FAIL padc_data[%0d] got %0d want %0d", k, got, exp_d[k]); end
      got = (k < oc.size()) ? oc[k] : -1;
      checks++; if (got != 3 + k) begin errors++; $display("FAIL padc_cycle[%0d] got %0d want %0d", k, got, 3 + k); end
    end
    got = (ma.size() == 2) ? ma[0] * 10000 + ma[1] : -1;
    checks++; if (got != 1) begin errors++; $display("FAIL padc_addrs got %0d want 1 (0 then 1)", got); end
    got = (ol.size() == 3) ? int'(ol[2]) + int'(oe[2]) : -1;
    checks++; if (got != 2) begin errors++; $display("FAIL padc_eol_last got %0d want 2", got); end
  endtask

  task automatic test_pad_replicate();
    int exp_d[4] = '{254, 255, 255, 255};
    int exp_a[4] = '{4094, 4095, 4095, 4095};
    int got;
    run_cmd(62, 63, 4, 1, 1, 1, 1'b1, 8'h00, 0, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rep_timeout got %b want 0", timeout); end
    checks++; if (od.size() != 4 || ma.size() != 4) begin errors++; $display("FAIL rep_counts got %0d/%0d want 4/4", od.size(), ma.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < od.size()) ? od[k] : -1;
      checks++; if (got != exp_d[k]) begin errors++; $display("FAIL rep_data[%0d] got %0d want %0d", k, got, exp_d[k]); end
      got = (k < ma.size()) ? ma[k] : -1;
      checks++; if (got != exp_a[k]) begin errors++; $display("FAIL rep_addr[%0d] got %0d want %0d", k, got, exp_a[k]); end
    end
  endtask

  task automatic test_stride();
    int exp_d[6] = '{0, 2, 4, 0, 2, 4};
    int exp_a[6] = '{0, 2, 4, 256, 258, 260};
    int got;
    run_cmd(0, 0, 3, 2, 2, 4, 1'b0, 8'h00, 0, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL stride_timeout got %b want 0", timeout); end
    for (int k = 0; k < 6; k++) begin
      got = (k < od.size()) ? od[k] : -1;
      checks++; if (got != exp_d[k]) begin errors++; $display("FAIL stride_data[%0d] got %0d want %0d", k, got, exp_d[k]); end
      got = (k < ma.size()) ? ma[k] : -1;
      checks++; if (got != exp_a[k]) begin errors++; $display("FAIL stride_addr[%0d] got %0d want %0d", k, got, exp_a[k]); end
      got = (k < oe.size()) ? int'(oe[k]) : -1;
      checks++; if (got != int'(k == 2 || k == 5)) begin errors++; $display("FAIL stride_eol[%0d] got %0d want %0d", k, got, int'(k == 2 || k == 5)); end
    end
  endtask

  task automatic test_stall();
    int exp_d[8] = '{194, 195, 196, 197, 2, 3, 4, 5};
    int got;
    run_cmd(2, 3, 4, 2, 1, 1, 1'b0, 8'h00, 1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL stall_timeout got %b want 0", timeout); end
    checks++; if (od.size() != 8) begin errors++; $display("FAIL stall_count got %0d want 8", od.size()); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL stall_hold got %0d violations want 0", hold_err); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_pulses got %0d want 1", done_cnt); end
    for (int k = 0; k < 8; k++) begin
      got = (k < od.size()) ? od[k] : -1;
      checks++; if (got != exp_d[k]) begin errors++; $display("FAIL stall_data[%0d] got %0d want %0d", k, got, exp_d[k]); end
      got = (k < ol.size()) ? int'(ol[k]) * 2 + int'(oe[k]) : -1;
      checks++; if (got != (k == 7 ? 3 : (k == 3 ? 1 : 0))) begin errors++; $display("FAIL stall_flags[%0d] got %0d want %0d", k, got, (k == 7 ? 3 : (k == 3 ? 1 : 0))); end
    end
  endtask

  task automatic test_reset_mid();
    int exp_d[4] = '{254, 255, 255, 255};
    int got;
    run_cmd(2, 3, 4, 2, 1, 1, 1'b0, 8'h00, 0, 3);
    checks++; if (od.size() != 3) begin errors++; $display("FAIL rmid_pre_count got %0d want 3", od.size()); end
    @(posedge clk); #1; rst_i = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0; #1;
    checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_out got v=%b busy=%b want 0/0", out_valid_o, busy_o); end
    checks++; if (cmd_ready_o !== 1'b1 || mem_re_o !== 1'b0) begin errors++; $display("FAIL rmid_ready got rdy=%b re=%b want 1/0", cmd_ready_o, mem_re_o); end
    run_cmd(62, 63, 4, 1, 1, 1, 1'b1, 8'h00, 0, 0);
    checks++; if (od.size() != 4 || timeout !== 1'b0) begin errors++; $display("FAIL rmid_post_count got %0d want 4", od.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < od.size()) ? od[k] : -1;
      checks++; if (got != exp_d[k]) begin errors++; $display("FAIL rmid_data[%0d] got %0d want %0d", k, got, exp_d[k]); end
    end
  endtask

  task automatic test_zero_size();
    run_cmd(5, 5, 0, 3, 1, 1, 1'b0, 8'h00, 0, 0);
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt); end
    checks++; if (valid_cyc != 0) begin errors++; $display("FAIL zero_out_valid got %0d cycles want 0", valid_cyc); end
    checks++; if (ma.size() != 0) begin errors++; $display("FAIL zero_reads got %0d want 0", ma.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad_const();
    test_pad_replicate();
    test_stride();
    test_stall();
    test_reset_mid();
    test_zero_size();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text2d_window_reader.md
# text2d_window_reader

Synthesizable 2D window fetcher: the RTL successor to the simulation-only text2d cache read path. It accepts a window command (origin, size, per-axis stride, padding mode), scans the window in raster order against a row-major frame memory with 1-cycle read latency, and streams elements out over a valid/ready handshake. Out-of-frame coordinates get either a constant pad value or the clamped edge value. It sits between a frame buffer RAM and downstream pixel/tile consumers.

## Interface
- BITDEPTH, 8, bits per channel sample
- CHANNELS, 1, samples per element; element width EW = BITDEPTH*CHANNELS
- FRAME_W, 64, frame width in elements
- FRAME_H, 64, frame height in elements
- MAX_WIN, 16, maximum window width/height
- ADDR_W, $clog2(FRAME_W*FRAME_H), memory address width
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_x, cmd_y  in  16  signed window origin
- cmd_w, cmd_h  in  $clog2(MAX_WIN+1)  window size in elements
- cmd_sx, cmd_sy  in  8  unsigned strides (0 treated as 1)
- cmd_pad_mode  in  1  0 = constant pad, 1 = replicate edge
- cmd_pad_value  in  EW  constant pad element
- mem_re  out  1  read enable
- mem_addr  out  ADDR_W  address = y*FRAME_W + x
- mem_rdata  in  EW  data valid the cycle after mem_re
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  EW  element
- out_eol  out  1  last element of a window row
- out_last  out  1  last element of the window
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse at window completion

## Operation
- FSM states: IDLE, SCAN, DRAIN. cmd_ready = (state==IDLE) && !rst.
- IDLE: accept latches all cmd fields. Go to SCAN if w,h nonzero. Otherwise pulse done next cycle and stay in IDLE with no output.
- SCAN: element (i,j), i inner. Coordinates x = cmd_x + i*sx and y = cmd_y + j*sy, computed in ≥18-bit signed arithmetic; no wrap.
- Per element, in-frame means 0≤x<FRAME_W and 0≤y<FRAME_H:
  - In-frame: issue mem_re at that address.
  - Out-of-frame, mode 1: clamp x,y to [0,FRAME_W-1] and [0,FRAME_H-1], then issue mem_re.
  - Out-of-frame, mode 0: no mem_re. A pad token travels the same 1-cycle slot, so element order is preserved.
- Each in-flight slot carries pad, eol and last flags. Results are written into a 2-entry output FIFO.
- Issue condition: fifo_count + inflight < 2, or a pop happens this cycle. The FIFO therefore never overflows.
- After the last element issues, go to DRAIN. Leave DRAIN when the FIFO is empty and the last element has handshaken. Then pulse done for 1 cycle, drop busy, and return to IDLE.
- out_data/out_eol/out_last are held stable while out_valid && !out_ready.
- mem_addr is 0 whenever mem_re=0.

## Timing
- Reset values: cmd_ready=1 (first cycle after reset). mem_re=0, mem_addr=0, out_valid=0, out_data=0, out_eol=0, out_last=0, busy=0, done=0. FIFO and in-flight slot are cleared.
- Latency: accept at cycle 0 → first mem_re at cycle 1 → FIFO write at end of cycle 2 → out_valid at cycle 3.
- With out_ready held high, throughput is 1 element/cycle with no bubbles, including across row boundaries and pad elements.
- done is asserted the cycle after the out_last handshake. cmd_ready rises the same cycle as done.
- Reset mid-window: the next cycle has all outputs at reset values. Any in-flight read is discarded. A new command may be accepted immediately.
- busy = (state != IDLE).

## Test plan
Frame 64x64 with mem[a] = a & 0xFF.
- x=2, y=3, w=4, h=2, s=1, out_ready=1 → out_data 194,195,196,197,2,3,4,5 on 8 consecutive cycles, starting 3 cycles after accept. out_eol on elements 4 and 8; out_last on element 8; done 1 cycle later.
- x=-1, y=0, w=3, h=1, mode 0, pad=0xAA → AA, 00, 01. mem_re is high for exactly 2 cycles; ordering intact.
- x=62, y=63, w=4, h=1, mode 1 → 254, 255, 255, 255 (addresses 4094, 4095, 4095, 4095).
- x=0, y=0, w=3, h=2, sx=2, sy=4 → addresses 0, 2, 4, 256, 258, 260; data 0, 2, 4, 0, 2, 4.
- Case 1 with out_ready toggling every cycle and random stalls → identical sequence, no loss or duplicate, data held during stalls, FIFO occupancy ≤2.
- Reset asserted after 3 outputs of case 1 → next cycle out_valid=0, busy=0, cmd_ready=1. A new case-3 command then produces the exact case-3 result.
- w=0 command → no out_valid; done pulses 1 cycle after accept.
